// File: rtl/seq_pkg.sv
// Shared defaults and overlap-mode encoding for the serial pattern detector.
package seq_pkg;

    localparam int          SEQ_PAT_W       = 4;
    localparam int          SEQ_CNT_W       = 8;
    localparam logic [3:0]  SEQ_DEFAULT_PAT = 4'b1011;
    localparam logic        SEQ_DEFAULT_OVL = 1'b1;

    localparam logic        OVL_ON          = 1'b1;
    localparam logic        OVL_OFF         = 1'b0;

    typedef enum logic {
        MODE_NONOVL = OVL_OFF,
        MODE_OVL    = OVL_ON
    } ovl_mode_e;

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with a clear that still counts a coincident increment.
module seq_sat_counter
    import seq_pkg::*;
#(
    parameter int CNT_W = SEQ_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            // A match on the clearing edge is the first event of the new count.
            count <= inc ? CNT_ONE : '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: MSB-first match against a loadable pattern, with
// overlapping or non-overlapping match modes and a saturating match counter.
module seq_pattern_detector
    import seq_pkg::*;
#(
    parameter int               PAT_W       = SEQ_PAT_W,
    parameter int               CNT_W       = SEQ_CNT_W,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = SEQ_DEFAULT_PAT,
    parameter logic             DEFAULT_OVL = SEQ_DEFAULT_OVL
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sequence_in,
    input  logic             in_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             count_clr,
    output logic             detector_out,
    output logic [CNT_W-1:0] match_count
);

    localparam int               FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);

    logic [PAT_W-1:0]  history;
    logic [PAT_W-1:0]  pattern;
    logic [FILL_W-1:0] fill;
    ovl_mode_e         mode;

    logic [PAT_W-1:0]  hist_next;
    logic [FILL_W-1:0] fill_inc;
    logic [FILL_W-1:0] fill_after;
    logic              match;

    // in_valid qualifies sequence_in with no backpressure: a bit is consumed on
    // every rising edge where in_valid=1 and cfg_load=0; otherwise it is dropped.
    always_comb begin
        hist_next  = {history[PAT_W-2:0], sequence_in};
        fill_inc   = (fill == FILL_MAX) ? FILL_MAX : fill + FILL_ONE;
        match      = in_valid && !cfg_load && (fill_inc == FILL_MAX) && (hist_next == pattern);
        fill_after = fill_inc;
        case (mode)
            MODE_OVL:    fill_after = fill_inc;
            MODE_NONOVL: fill_after = match ? '0 : fill_inc;
            default:     fill_after = fill_inc;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            history      <= '0;
            fill         <= '0;
            pattern      <= DEFAULT_PAT;
            mode         <= ovl_mode_e'(DEFAULT_OVL);
            detector_out <= 1'b0;
        end else begin
            detector_out <= match;
            if (cfg_load) begin
                pattern <= cfg_pattern;
                mode    <= ovl_mode_e'(cfg_overlap);
                fill    <= '0;
            end else if (in_valid) begin
                history <= hist_next;
                fill    <= fill_after;
            end
        end
    end

    seq_sat_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clock (clock),
        .reset (reset),
        .inc   (match),
        .clr   (count_clr),
        .count (match_count)
    );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: directed scenarios plus random traffic checked
// against a bit-queue reference model; a second instance uses a 2-bit counter.
module tb_seq_pattern_detector;

    localparam int EXP_W = 11;

    logic       clock;
    logic       reset;
    logic       sequence_in;
    logic       in_valid;
    logic       cfg_load;
    logic [3:0] cfg_pattern;
    logic       cfg_overlap;
    logic       count_clr;
    logic       detector_out;
    logic [7:0] match_count;
    logic       detector_out2;
    logic [1:0] match_count2;

    int total = 0;
    int bad   = 0;

    logic [EXP_W-1:0] exp_q[$];
    bit               m_bits[$];
    logic [3:0]       m_pat;
    logic             m_ovl;
    logic             m_det;
    int               m_cnt;
    int               m_cnt2;

    seq_pattern_detector dut (
        .clock        (clock),
        .reset        (reset),
        .sequence_in  (sequence_in),
        .in_valid     (in_valid),
        .cfg_load     (cfg_load),
        .cfg_pattern  (cfg_pattern),
        .cfg_overlap  (cfg_overlap),
        .count_clr    (count_clr),
        .detector_out (detector_out),
        .match_count  (match_count)
    );

    seq_pattern_detector #(.CNT_W(2)) dut2 (
        .clock        (clock),
        .reset        (reset),
        .sequence_in  (sequence_in),
        .in_valid     (in_valid),
        .cfg_load     (cfg_load),
        .cfg_pattern  (cfg_pattern),
        .cfg_overlap  (cfg_overlap),
        .count_clr    (count_clr),
        .detector_out (detector_out2),
        .match_count  (match_count2)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [EXP_W-1:0] observed();
        return {detector_out & detector_out2, match_count, match_count2};
    endfunction

    // ---------------- driver + reference model ----------------
    // Model: the bits received since fill was last cleared, newest at the back;
    // a match is the last four bits equalling the pattern.
    task automatic step(input logic rst, input logic v, input logic b, input logic ld,
                        input logic [3:0] pat, input logic ovl, input logic clr);
        logic       hit;
        logic [3:0] w;
        reset       = rst;
        in_valid    = v;
        sequence_in = b;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_overlap = ovl;
        count_clr   = clr;
        @(posedge clock);
        hit = 1'b0;
        if (!rst) begin
            m_bits.delete();
            m_pat  = 4'b1011;
            m_ovl  = 1'b1;
            m_cnt  = 0;
            m_cnt2 = 0;
        end else begin
            if (ld) begin
                m_pat = pat;
                m_ovl = ovl;
                m_bits.delete();
            end else if (v) begin
                m_bits.push_back(b);
                if (m_bits.size() > 4) void'(m_bits.pop_front());
                if (m_bits.size() == 4) begin
                    w   = {m_bits[0], m_bits[1], m_bits[2], m_bits[3]};
                    hit = (w == m_pat);
                end
                if (hit && !m_ovl) m_bits.delete();
            end
            if (clr) begin
                m_cnt  = hit ? 1 : 0;
                m_cnt2 = hit ? 1 : 0;
            end else if (hit) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        m_det = hit;
        exp_q.push_back({m_det, 8'(m_cnt), 2'(m_cnt2)});
        #1;
    endtask

    task automatic bit_in(input logic b);
        step(1'b1, 1'b1, b, 1'b0, 4'b0000, 1'b0, 1'b0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [EXP_W-1:0] e, o;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1);
            e = exp_q.pop_front(); o = observed(); total++;
            if (o !== e || o !== '0) begin
                bad++;
                $display("FAIL reset cyc%0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_basic();
        logic [3:0] s = 4'b1011;
        logic [EXP_W-1:0] e, o;
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 4; i++) begin
            bit_in(s[3-i]);
            e = exp_q.pop_front(); o = observed(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL basic bit%0d: got %h want %h", i + 1, o, e);
            end
        end
        total++;
        if (detector_out !== 1'b1 || match_count !== 8'd1) begin
            bad++;
            $display("FAIL basic_final: got det=%0b cnt=%0d want det=1 cnt=1", detector_out, match_count);
        end
    endtask

    task automatic test_overlap(input logic ovl);
        logic [6:0] s = 7'b1011011;
        logic [EXP_W-1:0] e, o;
        int pulses = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'b1011, ovl, 1'b0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 7; i++) begin
            bit_in(s[6-i]);
            pulses += int'(detector_out);
            e = exp_q.pop_front(); o = observed(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL overlap%0b bit%0d: got %h want %h", ovl, i + 1, o, e);
            end
        end
        total++;
        if (pulses != (ovl ? 2 : 1) || match_count !== (ovl ? 8'd2 : 8'd1)) begin
            bad++;
            $display("FAIL overlap%0b_total: got pulses=%0d cnt=%0d want %0d", ovl, pulses, match_count, ovl ? 2 : 1);
        end
    endtask

    task automatic test_gap_and_reset();
        logic [EXP_W-1:0] e, o;
        logic [3:0] s;
        int pulses = 0;
        // 1,0, three idle cycles, 1,1
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 7; i++) begin
            case (i)
                0:       bit_in(1'b1);
                1:       bit_in(1'b0);
                2, 3, 4: step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
                default: bit_in(1'b1);
            endcase
            e = exp_q.pop_front(); o = observed(); total++;
            if (o !== e || (i == 6 && detector_out !== 1'b1)) begin
                bad++;
                $display("FAIL gap cyc%0d: got %h want %h", i, o, e);
            end
        end
        // non-default pattern, partial 1,0,1, reset, then 1,0,1,1 on restored default
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        s = 4'b1011;
        for (int i = 0; i < 8; i++) begin
            if (i < 3)       bit_in(s[3-i]);
            else if (i == 3) step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
            else             bit_in(s[7-i]);
            if (i > 3) pulses += int'(detector_out);
            e = exp_q.pop_front(); o = observed(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL mid_reset cyc%0d: got %h want %h", i, o, e);
            end
        end
        total++;
        if (pulses != 1 || detector_out !== 1'b1) begin
            bad++;
            $display("FAIL default_pat_restored: got pulses=%0d det=%0b want 1 1", pulses, detector_out);
        end
    endtask

    task automatic test_zero_pattern();
        logic [EXP_W-1:0] e, o;
        logic [4:0] want = 5'b00011;
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        // the 0 offered alongside cfg_load must not count toward the match
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 5; i++) begin
            bit_in(1'b0);
            e = exp_q.pop_front(); o = observed(); total++;
            if (o !== e || detector_out !== want[4-i]) begin
                bad++;
                $display("FAIL zero_pat bit%0d: got %h det=%0b want %h", i + 1, o, detector_out, e);
            end
        end
    endtask

    task automatic test_saturate_and_clear();
        logic [3:0] s = 4'b1011;
        logic [EXP_W-1:0] e, o;
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 20; i++) begin
            bit_in(s[3-(i%4)]);
            e = exp_q.pop_front(); o = observed(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL saturate bit%0d: got %h want %h", i + 1, o, e);
            end
        end
        total++;
        if (match_count2 !== 2'd3 || match_count !== 8'd5) begin
            bad++;
            $display("FAIL saturate_final: got cnt2=%0d cnt=%0d want 3 5", match_count2, match_count);
        end
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
        repeat (3) void'(exp_q.pop_front());
        e = exp_q.pop_front(); o = observed(); total++;
        if (o !== e || match_count !== 8'd1 || match_count2 !== 2'd1) begin
            bad++;
            $display("FAIL clr_with_match: got %h want %h", o, e);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        e = exp_q.pop_front(); o = observed(); total++;
        if (o !== e || match_count !== 8'd0) begin
            bad++;
            $display("FAIL clr_alone: got %h want %h", o, e);
        end
    endtask

    task automatic test_random();
        logic [EXP_W-1:0] e, o;
        logic [3:0] pats[4] = '{4'b1011, 4'b0000, 4'b1111, 4'b0101};
        logic [3:0] p;
        for (int i = 0; i < 1500; i++) begin
            p = ($urandom_range(0, 4) == 4) ? 4'($urandom) : pats[$urandom_range(0, 3)];
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
                 $urandom_range(0, 24) == 0, p, 1'($urandom), $urandom_range(0, 29) == 0);
            e = exp_q.pop_front(); o = observed(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL random cyc%0d: got %h want %h", i, o, e);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset = 1'b0; sequence_in = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
        cfg_pattern = 4'b0000; cfg_overlap = 1'b0; count_clr = 1'b0;
        test_reset();
        test_basic();
        test_overlap(1'b1);
        test_overlap(1'b0);
        test_gap_and_reset();
        test_zero_pattern();
        test_saturate_and_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_pattern_detector.md
SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter CNT_W, default 8: match counter width, legal range 1..16.
REQ-003 Parameter DEFAULT_PAT, default 4'b1011 (PAT_W bits): pattern value loaded at reset.
REQ-004 Parameter DEFAULT_OVL, default 1: overlap mode value loaded at reset.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising edge of clock.
REQ-007 sequence_in  input  1  serial data bit.
REQ-008 in_valid  input  1  sequence_in is sampled only when 1.
REQ-009 cfg_load  input  1  load cfg_pattern / cfg_overlap this cycle.
REQ-010 cfg_pattern  input  PAT_W  new pattern; MSB is the first bit received.
REQ-011 cfg_overlap  input  1  new mode: 1 = overlapping matches, 0 = non-overlapping.
REQ-012 count_clr  input  1  clear match counter.
REQ-013 detector_out  output  1  registered one-cycle match pulse.
REQ-014 match_count  output  CNT_W  saturating count of matches.

Function
REQ-015 The block SHALL hold a PAT_W-bit history shift register, a fill counter (0..PAT_W, saturating), a pattern register and a mode register.
REQ-016 On an edge with in_valid=1 and cfg_load=0, history SHALL shift left with sequence_in entering the LSB, and fill SHALL increment, saturating at PAT_W.
REQ-017 A match SHALL occur on that edge when post-shift fill == PAT_W and post-shift history == pattern register.
REQ-018 detector_out SHALL be registered: 1 for exactly the cycle following the edge that sampled the last pattern bit; 0 otherwise. There is no combinational path from inputs to outputs.
REQ-019 Overlap mode 1: on a match, fill SHALL remain PAT_W, so the next valid bit can complete another match.
REQ-020 Overlap mode 0: on a match, fill SHALL clear to 0, so the next match needs PAT_W fresh valid bits.
REQ-021 When in_valid=0, history and fill SHALL hold and detector_out SHALL be 0; gaps in valid do not break a sequence.
REQ-022 cfg_load=1 SHALL load the pattern and mode registers, clear fill to 0, and force detector_out to 0 next cycle. cfg_load takes priority over in_valid: the bit offered in that cycle is dropped.
REQ-023 On each match, match_count SHALL increment by 1 and saturate at 2^CNT_W-1 (no wrap).
REQ-024 count_clr=1 SHALL set match_count to 0. If a match occurs on the same edge, match_count SHALL become 1.
REQ-025 Matches SHALL remain active regardless of counter saturation.

Reset
REQ-026 On reset=0 at a rising edge:
- history and fill SHALL be 0;
- detector_out SHALL be 0;
- match_count SHALL be 0;
- the pattern register SHALL be DEFAULT_PAT;
- the mode register SHALL be DEFAULT_OVL.
REQ-027 Reset SHALL override cfg_load, count_clr and in_valid. A partial sequence in progress at reset SHALL be discarded.

Structure
REQ-028 Package seq_pkg SHALL hold the default values of PAT_W, CNT_W, DEFAULT_PAT and DEFAULT_OVL, and the overlap-mode encoding constants.
REQ-029 The saturating counter SHALL be a sub-module, seq_sat_counter, parametrised by CNT_W, with inputs clock, reset, inc, clr and output count.
REQ-030 Implementation SHALL be 120-400 lines of RTL, with no latches and a full case/default on all decode.

Verification
REQ-031 Default config, valid bits 1,0,1,1 -> detector_out=1 one cycle after the 4th bit; match_count=1.
REQ-032 Overlap=1, bits 1,0,1,1,0,1,1 -> pulses after bits 4 and 7; match_count=2. Same stream with cfg_overlap=0 loaded -> single pulse after bit 4; match_count=1.
REQ-033 Bits 1,0, then in_valid=0 for 3 cycles, then 1,1 -> pulse after the final bit. Bits 1,0,1, then reset=0 for one cycle, then 1 -> no pulse; pattern reads back as 1011.
REQ-034 cfg_load pattern 0000 with overlap=1, then bits 0,0,0,0,0 -> pulses after bits 4 and 5. A bit offered in the cfg_load cycle is ignored.
REQ-035 CNT_W=2, 5 matches -> match_count stays 3. count_clr coincident with a match -> match_count=1 next cycle.
